// File: rtl/fifo_slot_pkg.sv
// ============================================================================
// Module   : fifo_slot_pkg
// Purpose  : Shared types and slot register map for the FIFO slot master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_slot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POLL   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } cmd_op_t;

    localparam logic [4:0] REG_STATUS = 5'd0;
    localparam logic [4:0] REG_WDATA  = 5'd1;
    localparam logic [4:0] REG_RDATA  = 5'd2;

    localparam int FULL_BIT  = 31;
    localparam int EMPTY_BIT = 30;

    localparam int STATS_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/fifo_slot_master.sv
// ============================================================================
// Module   : fifo_slot_master
// Purpose  : Turns push/pop commands into status-polled MMIO slot accesses.
//            Define FIFO_SLOT_MASTER_STATS_EN to add push/pop/timeout counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_slot_master
    import fifo_slot_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_POLL   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  cs,
    output logic                  read,
    output logic                  write,
    output logic [4:0]            addr,
    output logic [31:0]           wr_data,
    input  logic [31:0]           rd_data
`ifdef FIFO_SLOT_MASTER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] push_cnt,
    output logic [STATS_WIDTH-1:0] pop_cnt,
    output logic [STATS_WIDTH-1:0] timeout_cnt
`endif
);

    localparam int c_PCNT_W = (MAX_POLL > 1) ? $clog2(MAX_POLL) : 1;
    localparam logic [c_PCNT_W-1:0] c_POLL_LAST = c_PCNT_W'(MAX_POLL - 1);

    state_t                r_state;
    state_t                w_next_state;
    cmd_op_t               r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic [c_PCNT_W-1:0]   r_poll_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic                  w_status_ok;
    logic                  w_poll_last;
    logic [31:0]           w_wdata_ext;

    // Status is address-independent, so it can be judged in the POLL cycle itself.
    assign w_status_ok = (r_op == OP_PUSH) ? ~rd_data[FULL_BIT] : ~rd_data[EMPTY_BIT];
    assign w_poll_last = (r_poll_cnt == c_POLL_LAST);
    assign w_wdata_ext = {{(32 - DATA_WIDTH){1'b0}}, r_data};

    generate
        if (DATA_WIDTH < 30) begin : g_spare_rd_bits
            logic w_unused_rd;
            assign w_unused_rd = ^rd_data[29:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin : p_state_reg
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : p_next_state
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_next_state = POLL;
                end
            end
            POLL: begin
                if (w_status_ok) begin
                    w_next_state = ACCESS;
                end else if (w_poll_last) begin
                    w_next_state = RESP;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin : p_outputs
        cmd_ready = 1'b0;
        cs        = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        addr      = REG_STATUS;
        wr_data   = '0;
        case (r_state)
            IDLE: cmd_ready = 1'b1;
            POLL: cs = 1'b1;
            ACCESS: begin
                cs = 1'b1;
                if (r_op == OP_PUSH) begin
                    write   = 1'b1;
                    addr    = REG_WDATA;
                    wr_data = w_wdata_ext;
                end else begin
                    read = 1'b1;
                    addr = REG_RDATA;
                end
            end
            default: ;
        endcase
    end

    // Response registers default to zero so every response is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin : p_datapath
        if (reset) begin
            r_op        <= OP_PUSH;
            r_data      <= '0;
            r_poll_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op_t'(cmd_op);
                        r_data     <= cmd_data;
                        r_poll_cnt <= '0;
                    end
                end
                POLL: begin
                    if (!w_status_ok) begin
                        if (w_poll_last) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    if (r_op == OP_POP) begin
                        r_rsp_data <= rd_data[DATA_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

`ifdef FIFO_SLOT_MASTER_STATS_EN
    logic w_push_inc;
    logic w_pop_inc;
    logic w_timeout_inc;

    assign w_push_inc    = (r_state == ACCESS) && (r_op == OP_PUSH);
    assign w_pop_inc     = (r_state == ACCESS) && (r_op == OP_POP);
    assign w_timeout_inc = (r_state == RESP) && r_rsp_err;

    sat_counter #(.WIDTH(STATS_WIDTH)) u_push_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push_inc),
        .cnt   (push_cnt)
    );

    sat_counter #(.WIDTH(STATS_WIDTH)) u_pop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop_inc),
        .cnt   (pop_cnt)
    );

    sat_counter #(.WIDTH(STATS_WIDTH)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_timeout_inc),
        .cnt   (timeout_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_slot_master.sv
// ============================================================================
// Module   : tb_fifo_slot_master
// Purpose  : Scoreboard bench for fifo_slot_master against a depth-4 slot core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_slot_master;

    localparam int DW    = 8;
    localparam int MP    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          cs, read, write;
    logic [4:0]    addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
`ifdef FIFO_SLOT_MASTER_STATS_EN
    logic [15:0]   push_cnt, pop_cnt, timeout_cnt;
`endif

    fifo_slot_master #(.DATA_WIDTH(DW), .MAX_POLL(MP)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .cs        (cs),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data)
`ifdef FIFO_SLOT_MASTER_STATS_EN
        ,
        .push_cnt    (push_cnt),
        .pop_cnt     (pop_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slot core model: depth-4 FIFO with combinational status/head read.
    logic [DW-1:0] core_mem [DEPTH];
    int            core_cnt = 0;
    initial for (int i = 0; i < DEPTH; i++) core_mem[i] = '0;

    always_comb begin
        rd_data            = '0;
        rd_data[31]        = (core_cnt == DEPTH);
        rd_data[30]        = (core_cnt == 0);
        rd_data[DW-1:0]    = core_mem[0];
    end

    always @(posedge clk) begin
        if (cs && write && core_cnt < DEPTH) begin
            core_mem[core_cnt] <= wr_data[DW-1:0];
            core_cnt <= core_cnt + 1;
        end else if (cs && read && core_cnt > 0) begin
            for (int i = 0; i < DEPTH - 1; i++) core_mem[i] <= core_mem[i+1];
            core_cnt <= core_cnt - 1;
        end
    end

    typedef struct {
        bit            op;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        bit            err;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_q[$];
    int            n_checks = 0;
    int            n_fails  = 0;
    int            n_wr = 0, n_rd = 0;
    int            exp_push = 0, exp_pop = 0, exp_tmo = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: bus protocol and response scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (read && write) chk("rd_wr_overlap", 32'd1, 32'd0);
            if ((read || write) && !cs) chk("strobe_without_cs", 32'd1, 32'd0);
            if (!cs) chk("idle_bus", {24'd0, read, write, addr, |wr_data}, 32'd0);
            if (cs && !read && !write) chk("poll_addr", {27'd0, addr}, 32'd0);
            if (write) begin
                n_wr++;
                chk("write_addr", {27'd0, addr}, 32'd1);
                if (exp_q.size() > 0) chk("wr_data", wr_data, {{(32-DW){1'b0}}, exp_q[0].data});
            end
            if (read) begin
                n_rd++;
                chk("read_addr", {27'd0, addr}, 32'd2);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.rdata});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_latency", cyc - e.acc + 1, e.lat);
                    chk("write_strobes", n_wr, (!e.err && e.op == 1'b0) ? 1 : 0);
                    chk("read_strobes", n_rd, (!e.err && e.op == 1'b1) ? 1 : 0);
                end
                n_wr = 0;
                n_rd = 0;
            end
        end
    end

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic issue(input bit op, input logic [DW-1:0] d);
        int   w;
        exp_t e;
        w = 0;
        while (!cmd_ready) begin
            @(posedge clk); #1;
            w++;
            if (w > 200) begin
                chk("cmd_ready_wait", 32'd0, 32'd1);
                return;
            end
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e.op = op; e.data = d; e.rdata = '0; e.err = 1'b0; e.acc = cyc; e.lat = 3;
        if (op == 1'b0) begin
            if (ref_q.size() < DEPTH) begin ref_q.push_back(d); exp_push++; end
            else begin e.err = 1'b1; e.lat = MP + 1; exp_tmo++; end
        end else begin
            if (ref_q.size() > 0) begin e.rdata = ref_q.pop_front(); exp_pop++; end
            else begin e.err = 1'b1; e.lat = MP + 1; exp_tmo++; end
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            w++;
            if (w > 500) begin
                chk("drain_timeout", exp_q.size(), 32'd0);
                exp_q.delete();
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        chk("reset_bus", {24'd0, cs, read, write, addr}, 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed: single push/pop, fill, overflow, drain, underflow.
        issue(1'b0, 8'hA5);
        issue(1'b1, 8'h00);
        issue(1'b0, 8'h11);
        issue(1'b0, 8'h22);
        issue(1'b0, 8'h33);
        issue(1'b0, 8'h44);
        issue(1'b0, 8'h55);
        for (int i = 0; i < 4; i++) issue(1'b1, 8'h00);
        issue(1'b1, 8'h00);
        drain();

        for (int i = 0; i < 40; i++) issue(1'($urandom_range(0, 1)), DW'($urandom));
        drain();

`ifdef FIFO_SLOT_MASTER_STATS_EN
        chk("push_cnt", {16'd0, push_cnt}, exp_push);
        chk("pop_cnt", {16'd0, pop_cnt}, exp_pop);
        chk("timeout_cnt", {16'd0, timeout_cnt}, exp_tmo);
`endif

        // Empty the core, then abort a pop while it is polling.
        while (ref_q.size() > 0) issue(1'b1, 8'h00);
        drain();
        issue(1'b1, 8'h00);
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        exp_q.delete();
        n_wr = 0;
        n_rd = 0;
        #1;
        chk("abort_bus", {29'd0, cs, read, write}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        exp_push = 0; exp_pop = 0; exp_tmo = 0;
        repeat (MP + 5) begin @(posedge clk); #1; end
`ifdef FIFO_SLOT_MASTER_STATS_EN
        chk("stats_cleared", {push_cnt, pop_cnt | timeout_cnt}, 32'd0);
`endif

        issue(1'b0, 8'h5A);
        issue(1'b1, 8'h00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
